// File: rtl/median_disp_window_gen.sv
// 3x3 disparity window generator for a median filter: builds a sliding window
// from the current pixel and two line-buffer rows, flagging interior windows.
module median_disp_window_gen #(
   parameter int DWIDTH = 8,
   parameter int AWIDTH = 11
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clken,
   input  logic [AWIDTH-1:0]     width,
   input  logic [AWIDTH-1:0]     height,
   input  logic [DWIDTH-1:0]     pix_in,
   input  logic [DWIDTH-1:0]     lb1_data,
   input  logic [DWIDTH-1:0]     lb2_data,
   output logic [9*DWIDTH-1:0]   win_out,
   output logic                  win_valid,
   output logic                  frame_done
);

   typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} state_t;

   state_t                state_reg;
   logic [AWIDTH-1:0]     col_reg;
   logic [AWIDTH-1:0]     row_reg;
   logic [AWIDTH-1:0]     width_reg;
   logic [AWIDTH-1:0]     height_reg;
   logic [DWIDTH-1:0]     pix_d_reg;
   logic [AWIDTH-1:0]     x_d_reg;
   logic [AWIDTH-1:0]     y_d_reg;
   logic                  clken_d_reg;
   logic                  last_reg;
   logic                  last_shift_reg;
   logic [9*DWIDTH-1:0]   win_reg;
   logic                  win_valid_reg;
   logic                  frame_done_reg;

   logic                  start;
   logic                  take;
   logic                  accept;
   logic [AWIDTH-1:0]     cur_x;
   logic [AWIDTH-1:0]     cur_y;
   logic [AWIDTH-1:0]     eff_w;
   logic [AWIDTH-1:0]     eff_h;
   logic                  at_end_col;
   logic                  at_last;
   logic [9*DWIDTH-1:0]   win_next;

   // A clken in IDLE or DONE begins a new frame at (0,0) with freshly sampled
   // dimensions; once the last pixel is taken, further strobes wait for DONE.
   assign start      = clken && ((state_reg == IDLE) || (state_reg == DONE));
   assign take       = clken && ((state_reg == FILL) || (state_reg == RUN)) && !last_reg;
   assign accept     = start || take;
   assign cur_x      = start ? '0 : col_reg;
   assign cur_y      = start ? '0 : row_reg;
   assign eff_w      = start ? width  : width_reg;
   assign eff_h      = start ? height : height_reg;
   assign at_end_col = (cur_x == eff_w - AWIDTH'(1));
   assign at_last    = at_end_col && (cur_y == eff_h - AWIDTH'(1));

   // Column c=2 of each row takes the new sample; c=0,1 take their right neighbour.
   genvar gi;
   generate
      for (gi = 0; gi < 9; gi++) begin : g_cell
         if ((gi % 3) == 2) begin : g_new
            if ((gi / 3) == 0) begin : g_r0
               assign win_next[DWIDTH*gi +: DWIDTH] = lb2_data;
            end else if ((gi / 3) == 1) begin : g_r1
               assign win_next[DWIDTH*gi +: DWIDTH] = lb1_data;
            end else begin : g_r2
               assign win_next[DWIDTH*gi +: DWIDTH] = pix_d_reg;
            end
         end else begin : g_shift
            assign win_next[DWIDTH*gi +: DWIDTH] = win_reg[DWIDTH*(gi+1) +: DWIDTH];
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         col_reg        <= '0;
         row_reg        <= '0;
         width_reg      <= '0;
         height_reg     <= '0;
         pix_d_reg      <= '0;
         x_d_reg        <= '0;
         y_d_reg        <= '0;
         clken_d_reg    <= 1'b0;
         last_reg       <= 1'b0;
         last_shift_reg <= 1'b0;
         win_reg        <= '0;
         win_valid_reg  <= 1'b0;
         frame_done_reg <= 1'b0;
      end else begin
         clken_d_reg    <= accept;
         last_shift_reg <= clken_d_reg && last_reg;
         frame_done_reg <= 1'b0;

         if (accept) begin
            pix_d_reg <= pix_in;
            x_d_reg   <= cur_x;
            y_d_reg   <= cur_y;
            if (start) begin
               width_reg  <= width;
               height_reg <= height;
            end
            if (at_end_col) begin
               col_reg <= '0;
               row_reg <= cur_y + AWIDTH'(1);
            end else begin
               col_reg <= cur_x + AWIDTH'(1);
               row_reg <= cur_y;
            end
            if (at_last) begin
               last_reg <= 1'b1;
            end
         end

         // Interior test on the shifted column: x>=2 and y>=2 can only occur
         // when the frame is at least 3x3, so tiny frames never emit windows.
         if (clken_d_reg) begin
            win_reg       <= win_next;
            win_valid_reg <= (x_d_reg >= AWIDTH'(2)) && (y_d_reg >= AWIDTH'(2));
         end else begin
            win_valid_reg <= 1'b0;
         end

         case (state_reg)
            IDLE: begin
               if (start) begin
                  state_reg <= FILL;
               end
            end
            FILL: begin
               if (last_shift_reg) begin
                  state_reg      <= DONE;
                  frame_done_reg <= 1'b1;
                  last_reg       <= 1'b0;
               end else if (accept && at_end_col && (cur_y == AWIDTH'(1)) && !at_last) begin
                  state_reg <= RUN;
               end
            end
            RUN: begin
               if (last_shift_reg) begin
                  state_reg      <= DONE;
                  frame_done_reg <= 1'b1;
                  last_reg       <= 1'b0;
               end
            end
            DONE: begin
               state_reg <= start ? FILL : IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign win_out    = win_reg;
   assign win_valid  = win_valid_reg;
   assign frame_done = frame_done_reg;

endmodule

// File: doc/median_disp_window_gen.md
MEDIAN_DISP_WINDOW_GEN -- requirements
Module: median_disp_window_gen

Interface
REQ-001 Parameter DWIDTH, default 8, sets the disparity sample width in bits.
REQ-002 Parameter AWIDTH, default 11, sets the column/row counter width in bits.
REQ-003 clk  input  1  Single clock; all state updates on the rising edge.
REQ-004 rst  input  1  Reset, synchronous and active-high.
REQ-005 clken  input  1  Pixel strobe: pix_in is valid this cycle, in raster order.
REQ-006 width  input  AWIDTH  Pixels per row; sampled at frame start.
REQ-007 height  input  AWIDTH  Rows per frame; sampled at frame start.
REQ-008 pix_in  input  DWIDTH  Current-row disparity sample P(x,y).
REQ-009 lb1_data  input  DWIDTH  Line-buffer read data for row y-1, column x; arrives the cycle after the clken that carried P(x,y).
REQ-010 lb2_data  input  DWIDTH  Line-buffer read data for row y-2, column x; same timing as lb1_data.
REQ-011 win_out  output  9*DWIDTH  Registered 3x3 window, element k=3r+c at bits [DWIDTH*k +: DWIDTH]; r=0 is row y-2, c=0 is column x-2; center is k=4.
REQ-012 win_valid  output  1  One-cycle pulse: win_out holds a complete interior window.
REQ-013 frame_done  output  1  One-cycle pulse after the last pixel of the frame has been shifted in.

Function
REQ-014 The block SHALL implement states IDLE, FILL, RUN and DONE.
REQ-015 In IDLE, clken SHALL latch width and height, accept the pixel as (0,0), and move to FILL.
REQ-016 FILL SHALL move to RUN at the end of row 1 (row counter advancing to 2).
REQ-017 RUN SHALL move to DONE in the cycle after the shift of pixel (width-1, height-1).
REQ-018 DONE SHALL last one cycle with frame_done=1, then go to IDLE.
REQ-019 A clken during DONE SHALL be accepted as pixel (0,0) of a new frame, with a transition to FILL instead of IDLE.
REQ-020 The column counter SHALL advance on each accepted clken and wrap from width-1 to 0.
REQ-021 The row counter SHALL increment on that wrap.
REQ-022 The block SHALL register pix_in and the (x,y) counters on clken, and SHALL register clken as clken_d.
REQ-023 On clken_d=1 the block SHALL shift column {lb2_data, lb1_data, pix_d} into the 3x3 register, dropping column c=0.
REQ-024 The block SHALL ignore lb1_data and lb2_data when clken_d=0.
REQ-025 Latency: for clken of P(x,y) at cycle t, win_out and win_valid SHALL update at t+2.
REQ-026 win_valid SHALL be 1 at t+2 only if x>=2 and y>=2 (window center at (x-1, y-1)); otherwise 0.
REQ-027 win_out SHALL hold its value when no shift occurs.
REQ-028 Gaps in clken of any length SHALL NOT change results; only the timing of outputs shifts.
REQ-029 If the latched width<3 or height<3, win_valid SHALL stay 0 for the whole frame while frame_done still pulses.
REQ-030 Pixels SHALL NOT be padded or replicated at the borders; border-centered windows SHALL NOT be emitted.
REQ-031 Changes to width or height during a frame SHALL have no effect until the next frame start.

Reset
REQ-032 While rst=1 at a clock edge, state SHALL be IDLE and all counters, pix_d, clken_d, the window register, win_out, win_valid and frame_done SHALL be 0.
REQ-033 rst SHALL take priority over clken, including mid-frame; the next clken after release SHALL start a new frame at (0,0).

Verification
REQ-034 The bench SHALL cover this scenario: width=4, height=4, continuous clken, P=16y+x, lb data modelled from the prior rows -> exactly 4 win_valid pulses with centers 17, 18, 33, 34; first win_out = {0,1,2,16,17,18,32,33,34} for k=0..8; frame_done 1 cycle after the last shift.
REQ-035 The bench SHALL cover this scenario: same frame with clken asserted every 3rd cycle -> identical win_out sequence, each window 2 cycles after its clken.
REQ-036 The bench SHALL cover this scenario: width=2, height=5 -> no win_valid, one frame_done pulse.
REQ-037 The bench SHALL cover this scenario: rst asserted at pixel (2,2) of a 4x4 frame, then a fresh 4x4 frame -> all outputs 0 during reset; fresh frame yields exactly 4 windows.
REQ-038 The bench SHALL cover this scenario: two back-to-back 4x4 frames with clken asserted in the DONE cycle -> 8 windows, 2 frame_done pulses; second frame's first window center = 17.
REQ-039 The bench SHALL cover this scenario: width changed from 4 to 6 mid-frame -> current frame still completes with 4 windows; the next frame uses width 6.
